// File: rtl/tour_cmd_seq.sv
// Replays the solver's stored knight moves as vertical/horizontal command pairs,
// and passes UART commands through to the command processor when no tour runs.
module tour_cmd_seq #(
  parameter int unsigned NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam int unsigned IW = 5;
  localparam logic [IW-1:0] LAST_INDX = IW'(NUM_MOVES - 1);
  localparam logic [7:0] RESP_BUSY = 8'hA5;
  localparam logic [7:0] RESP_DONE = 8'h5A;

  typedef enum logic [2:0] {IDLE, XM_V, WT_V, XM_H, WT_H} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] mv_indx_nxt;
  logic [7:0]    resp_nxt;

  logic [1:0]  dx_mag, dy_mag;
  logic        dx_neg, dy_neg;
  logic [7:0]  v_head, h_head;
  logic [15:0] v_cmd, h_cmd;

  // One-hot move to signed offsets; anything else is no motion.
  always_comb begin
    dx_mag = 2'd0;
    dy_mag = 2'd0;
    dx_neg = 1'b0;
    dy_neg = 1'b0;
    case (move)
      8'h01: begin dx_mag = 2'd1; dx_neg = 1'b1; dy_mag = 2'd2;                end
      8'h02: begin dx_mag = 2'd1;                dy_mag = 2'd2;                end
      8'h04: begin dx_mag = 2'd2; dx_neg = 1'b1; dy_mag = 2'd1;                end
      8'h08: begin dx_mag = 2'd2; dx_neg = 1'b1; dy_mag = 2'd1; dy_neg = 1'b1; end
      8'h10: begin dx_mag = 2'd1; dx_neg = 1'b1; dy_mag = 2'd2; dy_neg = 1'b1; end
      8'h20: begin dx_mag = 2'd1;                dy_mag = 2'd2; dy_neg = 1'b1; end
      8'h40: begin dx_mag = 2'd2;                dy_mag = 2'd1; dy_neg = 1'b1; end
      8'h80: begin dx_mag = 2'd2;                dy_mag = 2'd1;                end
      default: ;
    endcase
  end

  // Zero offset leaves the heading at north.
  always_comb begin
    v_head = (dy_mag != 2'd0 && dy_neg) ? 8'h7F : 8'h00;
    h_head = 8'h00;
    if (dx_mag != 2'd0) h_head = dx_neg ? 8'h3F : 8'hBF;
    v_cmd = {4'h2, v_head, 2'b00, dy_mag};
    h_cmd = {4'h3, h_head, 2'b00, dx_mag};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
      resp    <= RESP_DONE;
    end else begin
      state   <= state_nxt;
      mv_indx <= mv_indx_nxt;
      resp    <= resp_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    mv_indx_nxt      = mv_indx;
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        if (start_tour) begin
          state_nxt   = XM_V;
          mv_indx_nxt = '0;
        end
      end
      XM_V: begin
        cmd     = v_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = WT_V;
      end
      WT_V: begin
        cmd = v_cmd;
        if (send_resp) state_nxt = XM_H;
      end
      XM_H: begin
        cmd     = h_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = WT_H;
      end
      WT_H: begin
        cmd = h_cmd;
        if (send_resp) begin
          if (mv_indx == LAST_INDX) begin
            state_nxt = IDLE;
          end else begin
            mv_indx_nxt = mv_indx + IW'(1);
            state_nxt   = XM_V;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response is registered from the upcoming state so it tracks the state exactly.
  always_comb begin
    resp_nxt = RESP_BUSY;
    if (state_nxt == IDLE || (state_nxt == WT_H && mv_indx_nxt == LAST_INDX))
      resp_nxt = RESP_DONE;
  end

endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Sequencer between the knight's-tour solver and the command processor. After the solver finishes, it walks the solver's 24 stored moves by driving the solver's move index. Each one-hot move becomes two movement commands: vertical leg first, then horizontal leg. It presents each command to the command processor with a ready/clear/response handshake. When no tour is running, it passes UART commands straight through to the command processor.

## Interface
Parameters:
- NUM_MOVES, 24: moves replayed per tour (solver indices 0..NUM_MOVES-1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk edge.
- start_tour  in  1  one-cycle pulse from solver done; starts replay.
- move  in  8  one-hot move returned by solver for the index on mv_indx (combinational solver read port).
- mv_indx  out  5  move index driven to solver.
- cmd_UART  in  16  command from UART wrapper.
- cmd_rdy_UART  in  1  UART command valid.
- clr_cmd_rdy_UART  out  1  clear to UART wrapper.
- cmd  out  16  command to command processor: [15:12] opcode, [11:4] heading, [3:0] squares.
- cmd_rdy  out  1  command valid to command processor.
- clr_cmd_rdy  in  1  command processor has accepted cmd.
- send_resp  in  1  command processor has completed the command.
- resp  out  8  response byte for the UART: 8'hA5 = tour in progress, 8'h5A = done or UART mode.

## Operation
Move decode (dx, dy):
- 01: (-1,+2)
- 02: (+1,+2)
- 04: (-2,+1)
- 08: (-2,-1)
- 10: (-1,-2)
- 20: (+1,-2)
- 40: (+2,-1)
- 80: (+2,+1)
- Any non-one-hot value decodes to (0,0).

Vertical command:
- Opcode 4'h2.
- Heading 8'h00 (north) if dy>0, 8'h7F (south) if dy<0.
- Squares = |dy|.

Horizontal command:
- Opcode 4'h3 (move with fanfare).
- Heading 8'hBF (east) if dx>0, 8'h3F (west) if dx<0.
- Squares = |dx|.
- A zero offset gives heading 8'h00 and squares 0.

FSM states and transitions:
- IDLE:
  - Pass-through: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
  - start_tour -> XM_V, with mv_indx cleared to 0.
- XM_V: cmd=vertical command; cmd_rdy=1; on clr_cmd_rdy -> WT_V.
- WT_V: cmd held; cmd_rdy=0; on send_resp -> XM_H.
- XM_H: cmd=horizontal command; cmd_rdy=1; on clr_cmd_rdy -> WT_H.
- WT_H: cmd_rdy=0; on send_resp:
  - if mv_indx==NUM_MOVES-1 -> IDLE;
  - otherwise mv_indx+1 -> XM_V.
- Outside IDLE: clr_cmd_rdy_UART=0 and cmd_rdy_UART is ignored; a pending UART command waits until the tour ends.

resp:
- 8'h5A in IDLE, and in WT_H when mv_indx==NUM_MOVES-1.
- 8'hA5 otherwise.

Width rules:
- mv_indx is 5-bit and never exceeds NUM_MOVES-1; it does not wrap.
- |dx|, |dy| ≤ 2, zero-extended into the 4-bit squares field.

## Timing
- Reset values: state IDLE, mv_indx 0, resp 8'h5A. cmd, cmd_rdy and clr_cmd_rdy_UART follow the pass-through inputs.
- Reset asserted mid-tour returns to IDLE at the next edge. The solver is not re-triggered.
- start_tour at edge N: cmd_rdy=1 and the vertical command for index 0 are valid from cycle N+1.
- cmd and cmd_rdy in XM/WT states are combinational from state and move. move must be stable within the cycle mv_indx changes.
- clr_cmd_rdy at edge N in XM_*: cmd_rdy=0 from cycle N+1.
- send_resp in XM_*, clr_cmd_rdy in WT_*, and start_tour outside IDLE are all ignored.
- clr_cmd_rdy and send_resp together in XM_*: only the clear is taken (-> WT_*). send_resp is required again in WT_*.
- Minimum cost: 4 cycles per move, so 96 cycles per tour with zero-latency handshakes.

## Test plan
- Reset: rst_n=0 for 2 edges with cmd_UART=16'h1234, cmd_rdy_UART=1 -> cmd=16'h1234, cmd_rdy=1, mv_indx=0, resp=8'h5A.
- Single move: start_tour with move=8'h01, then immediate clr/send each leg -> cmd 16'h2002, then 16'h33F1; resp=8'hA5; mv_indx becomes 1 after the second send_resp.
- Decode sweep: moves 08, 80, 20 -> leg pairs (16'h27F1, 16'h33F2), (16'h2001, 16'hBF2 with opcode 3, i.e. 16'h3BF2), (16'h27F2, 16'h3BF1).
- Full tour: 24 moves with random handshake delays (0-10 cycles) -> exactly 48 cmd_rdy rising edges, mv_indx 0..23 in order, resp=8'h5A during the final WT_H, IDLE afterwards, pass-through restored.
- Mux isolation: cmd_rdy_UART=1 mid-tour -> clr_cmd_rdy_UART=0 and cmd never equals cmd_UART; start_tour pulsed mid-tour leaves mv_indx unchanged.
- Reset mid-tour at mv_indx=7 in WT_V -> IDLE next edge, mv_indx=0, resp=8'h5A, a new start_tour restarts from index 0.
